enemy_formation: RTL and testbench

- Sequential controller that owns the invader formation state consumed by color_mapper: enemy_offset, animation_offset, enemy_status.
- Marches the formation horizontally on frame ticks and reverses at the screen edges, using the live-column extent to decide when to reverse.
- Clears enemies on hit reports from the collision logic, pulses a kill strobe to the score counter, and reloads a new wave after the formation is cleared.

---
 rtl/enemy_formation.sv | 231 +++++++++++++++++++++++
 tb/tb_enemy_formation.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_formation.sv
// -----------------------------------------------------------------------------
// enemy_formation
//   Owns the invader formation state that color_mapper draws from. It marches
//   the block left and right on frame ticks, reverses it at the screen edges
//   based on the right-most live column, removes invaders on hit reports from
//   the collision logic, and reloads a fresh wave after a delay once the
//   formation has been wiped out.
//
//   Optional build macro: ENEMY_SPEEDUP_EN
//     undefined : march period is BASE_PERIOD frames per step
//     defined   : march period is (alive_count >> 2) + 1 frames per step
//
// Ports
//   Clk              in   system clock
//   Reset_n          in   asynchronous active-low reset
//   frame_tick       in   one-Clk pulse per frame
//   freeze           in   level, suspends marching and frame counting
//   hit_valid        in   one-Clk hit report
//   hit_col[3:0]     in   hit column index
//   hit_row[2:0]     in   hit row index
//   enemy_offset     out  left X of column 0 (pixels)
//   animation_offset out  sprite frame select, 0 or 8
//   enemy_status     out  alive bits, [col][row]
//   kill_pulse       out  one-Clk pulse per accepted hit
//   wave_clear       out  high while the cleared-wave delay is running
// -----------------------------------------------------------------------------
module enemy_formation #(
   parameter int STEP_PX     = 4,
   parameter int BASE_PERIOD = 16,
   parameter int INIT_COLS   = 8,
   parameter int WAVE_DELAY  = 120,
   parameter int SCREEN_W    = 640
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             frame_tick,
   input  logic             freeze,
   input  logic             hit_valid,
   input  logic [3:0]       hit_col,
   input  logic [2:0]       hit_row,
   output logic [9:0]       enemy_offset,
   output logic [7:0]       animation_offset,
   output logic [9:0][5:0]  enemy_status,
   output logic             kill_pulse,
   output logic             wave_clear
);

   typedef logic [9:0][5:0] status_t;

   typedef enum logic [1:0] {
      ST_MARCH   = 2'd0,
      ST_CLEARED = 2'd1,
      ST_RELOAD  = 2'd2
   } state_t;

   // Fresh-wave pattern: the first INIT_COLS columns fully populated.
   function automatic status_t init_status();
      status_t s;
      s = '0;
      for (int c = 0; c < 10; c++) begin
         if (c < INIT_COLS) begin
            s[c] = 6'h3F;
         end else begin
            s[c] = 6'h00;
         end
      end
      return s;
   endfunction

   // Highest column index holding any live invader (0 when none are alive).
   function automatic logic [3:0] highest_col(input status_t s);
      logic [3:0] l;
      l = 4'd0;
      for (int c = 0; c < 10; c++) begin
         if (|s[c]) begin
            l = 4'(c);
         end else begin
            l = l;
         end
      end
      return l;
   endfunction

`ifdef ENEMY_SPEEDUP_EN
   // Number of live invaders (at most 60, fits in 6 bits).
   function automatic logic [5:0] alive_count(input status_t s);
      logic [5:0] n;
      n = 6'd0;
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < 6; r++) begin
            n = n + 6'(s[c][r]);
         end
      end
      return n;
   endfunction
`endif

   state_t     state_r;
   status_t    enemy_status_r;
   logic [9:0] enemy_offset_r;
   logic [7:0] animation_r;
   logic       dir_right_r;
   logic [7:0] frame_cnt_r;
   logic [7:0] wave_cnt_r;
   logic       kill_pulse_r;
   logic       wave_clear_r;

   logic        tick_s;
   logic [7:0]  period_s;
   logic        step_due_s;
   logic        hit_accept_s;
   logic [3:0]  lmax_s;
   logic [10:0] off_ext_s;
   logic [10:0] right_edge_s;
   logic        edge_block_s;
   logic [10:0] next_offset_s;
   logic        wave_done_s;
   logic        all_dead_s;

   // Step decision, edge test and hit qualification, all from registered state.
   always_comb begin
      tick_s        = frame_tick & ~freeze;
`ifdef ENEMY_SPEEDUP_EN
      period_s      = {2'b00, (alive_count(enemy_status_r) >> 2)} + 8'd1;
`else
      period_s      = 8'(BASE_PERIOD);
`endif
      // ">=" rather than "==" so a period that shrinks below the running
      // count (speed-up build) still fires on the next tick instead of wrapping.
      step_due_s    = (frame_cnt_r + 8'd1) >= period_s;
      wave_done_s   = (wave_cnt_r + 8'd1) >= 8'(WAVE_DELAY);
      all_dead_s    = (enemy_status_r == '0);

      // Edge tests use the pre-hit status so a coincident hit cannot move the bound.
      lmax_s        = highest_col(enemy_status_r);
      off_ext_s     = {1'b0, enemy_offset_r};
      right_edge_s  = off_ext_s + 11'(STEP_PX) + {1'b0, lmax_s, 6'd0} + 11'd32;

      if (dir_right_r) begin
         edge_block_s = right_edge_s > 11'(SCREEN_W);
      end else begin
         edge_block_s = off_ext_s < 11'(STEP_PX);
      end

      if (edge_block_s) begin
         next_offset_s = off_ext_s;
      end else if (dir_right_r) begin
         next_offset_s = off_ext_s + 11'(STEP_PX);
      end else begin
         next_offset_s = off_ext_s - 11'(STEP_PX);
      end

      if ((state_r == ST_MARCH) && hit_valid && (hit_col < 4'd10) && (hit_row < 3'd6)) begin
         hit_accept_s = enemy_status_r[hit_col][hit_row];
      end else begin
         hit_accept_s = 1'b0;
      end
   end

   // Formation state machine: march/hit handling, wave-clear delay and reload.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r        <= ST_MARCH;
         enemy_status_r <= init_status();
         enemy_offset_r <= 10'd0;
         animation_r    <= 8'd0;
         dir_right_r    <= 1'b1;
         frame_cnt_r    <= 8'd0;
         wave_cnt_r     <= 8'd0;
         kill_pulse_r   <= 1'b0;
         wave_clear_r   <= 1'b0;
      end else begin
         kill_pulse_r <= 1'b0;
         case (state_r)
            ST_MARCH: begin
               if (hit_accept_s) begin
                  enemy_status_r[hit_col][hit_row] <= 1'b0;
                  kill_pulse_r                     <= 1'b1;
               end
               if (tick_s) begin
                  if (step_due_s) begin
                     frame_cnt_r    <= 8'd0;
                     enemy_offset_r <= next_offset_s[9:0];
                     dir_right_r    <= dir_right_r ^ edge_block_s;
                     animation_r    <= animation_r ^ 8'd8;
                  end else begin
                     frame_cnt_r <= frame_cnt_r + 8'd1;
                  end
               end
               // The empty formation is seen one cycle after the last kill lands.
               if (all_dead_s) begin
                  state_r      <= ST_CLEARED;
                  wave_cnt_r   <= 8'd0;
                  wave_clear_r <= 1'b1;
               end
            end
            ST_CLEARED: begin
               if (tick_s) begin
                  if (wave_done_s) begin
                     state_r      <= ST_RELOAD;
                     wave_clear_r <= 1'b0;
                  end else begin
                     wave_cnt_r <= wave_cnt_r + 8'd1;
                  end
               end
            end
            ST_RELOAD: begin
               state_r        <= ST_MARCH;
               enemy_status_r <= init_status();
               enemy_offset_r <= 10'd0;
               animation_r    <= 8'd0;
               dir_right_r    <= 1'b1;
               frame_cnt_r    <= 8'd0;
               wave_cnt_r     <= 8'd0;
               wave_clear_r   <= 1'b0;
            end
            default: begin
               state_r      <= ST_MARCH;
               wave_clear_r <= 1'b0;
            end
         endcase
      end
   end

   assign enemy_offset     = enemy_offset_r;
   assign animation_offset = animation_r;
   assign enemy_status     = enemy_status_r;
   assign kill_pulse       = kill_pulse_r;
   assign wave_clear       = wave_clear_r;

endmodule

// File: tb/tb_enemy_formation.sv
// -----------------------------------------------------------------------------
// tb_enemy_formation
//   Directed bench for enemy_formation. A frame-level model of the formation
//   (integer offset, per-invader alive array, phase number) advances on every
//   clock and is compared with the DUT outputs on every falling edge. Literal
//   expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_enemy_formation;

   localparam int          STEP_PX     = 4;
   localparam int          BASE_PERIOD = 16;
   localparam int          WAVE_DELAY  = 120;
   localparam int          SCREEN_W    = 640;
   localparam logic [59:0] INIT_STAT   = 60'h000FFFFFFFFFFFF;

   logic            Clk = 1'b0;
   logic            Reset_n = 1'b0;
   logic            frame_tick = 1'b0;
   logic            freeze = 1'b0;
   logic            hit_valid = 1'b0;
   logic [3:0]      hit_col = 4'd0;
   logic [2:0]      hit_row = 3'd0;
   logic [9:0]      enemy_offset;
   logic [7:0]      animation_offset;
   logic [9:0][5:0] enemy_status;
   logic            kill_pulse;
   logic            wave_clear;

   int n_cmp = 0;
   int n_bad = 0;
   int kills_seen = 0;
   int k0;

   // model state
   int              m_off, m_anim, m_right, m_fcnt, m_wcnt, m_phase;
   logic [9:0][5:0] m_stat;
   logic            m_kill, m_wclr;

   enemy_formation dut (
      .Clk              (Clk),
      .Reset_n          (Reset_n),
      .frame_tick       (frame_tick),
      .freeze           (freeze),
      .hit_valid        (hit_valid),
      .hit_col          (hit_col),
      .hit_row          (hit_row),
      .enemy_offset     (enemy_offset),
      .animation_offset (animation_offset),
      .enemy_status     (enemy_status),
      .kill_pulse       (kill_pulse),
      .wave_clear       (wave_clear)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_off   = 0;
      m_anim  = 0;
      m_right = 1;
      m_fcnt  = 0;
      m_wcnt  = 0;
      m_phase = 0;
      m_stat  = INIT_STAT;
      m_kill  = 1'b0;
      m_wclr  = 1'b0;
   endtask

   task automatic model_clock();
      int lmax;
      int alive;
      int period;
      bit tick;
      bit hit_ok;
      lmax  = 0;
      alive = 0;
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < 6; r++) begin
            if (m_stat[c][r]) begin
               lmax = c;
               alive++;
            end
         end
      end
      tick   = frame_tick && !freeze;
      hit_ok = 1'b0;
      if (m_phase == 0 && hit_valid && int'(hit_col) < 10 && int'(hit_row) < 6)
         hit_ok = m_stat[hit_col][hit_row];
      m_kill = hit_ok;
      if (m_phase == 0) begin
         if (tick) begin
`ifdef ENEMY_SPEEDUP_EN
            period = alive / 4 + 1;
`else
            period = BASE_PERIOD;
`endif
            if (m_fcnt + 1 >= period) begin
               m_fcnt = 0;
               if (m_right != 0) begin
                  if (m_off + STEP_PX + 64 * lmax + 32 > SCREEN_W) m_right = 0;
                  else m_off = m_off + STEP_PX;
               end else begin
                  if (m_off < STEP_PX) m_right = 1;
                  else m_off = m_off - STEP_PX;
               end
               m_anim = (m_anim == 0) ? 8 : 0;
            end else begin
               m_fcnt++;
            end
         end
         if (hit_ok) m_stat[hit_col][hit_row] = 1'b0;
         if (alive == 0) begin
            m_phase = 1;
            m_wcnt  = 0;
            m_wclr  = 1'b1;
         end
      end else if (m_phase == 1) begin
         if (tick) begin
            m_wcnt++;
            if (m_wcnt >= WAVE_DELAY) begin
               m_phase = 2;
               m_wclr  = 1'b0;
            end
         end
      end else begin
         model_reset();
      end
   endtask

   // model advance
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) model_reset();
      else model_clock();
   end

   // cycle-by-cycle comparison against the model
   always @(negedge Clk) begin
      chk("offset", 64'(enemy_offset), 64'(m_off));
      chk("anim", 64'(animation_offset), 64'(m_anim));
      chk("status", 64'(enemy_status), 64'(m_stat));
      chk("kill", 64'(kill_pulse), 64'(m_kill));
      chk("wave_clear", 64'(wave_clear), 64'(m_wclr));
      if (kill_pulse) kills_seen++;
   end

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         frame_tick = 1'b1;
         @(negedge Clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic steps(input int n);
      tick_n(BASE_PERIOD * n);
   endtask

   task automatic hit(input int c, input int r);
      @(negedge Clk);
      hit_valid = 1'b1;
      hit_col   = 4'(c);
      hit_row   = 3'(r);
      @(negedge Clk);
      hit_valid = 1'b0;
   endtask

   task automatic tick_hit(input int c, input int r);
      @(negedge Clk);
      frame_tick = 1'b1;
      hit_valid  = 1'b1;
      hit_col    = 4'(c);
      hit_row    = 3'(r);
      @(negedge Clk);
      frame_tick = 1'b0;
      hit_valid  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("lit_reset_offset", 64'(enemy_offset), 64'd0);
      chk("lit_reset_anim", 64'(animation_offset), 64'd0);
      chk("lit_reset_status", 64'(enemy_status), 64'(INIT_STAT));
      chk("lit_reset_wclr", 64'(wave_clear), 64'd0);

      tick_n(16);
      chk("lit_step1_offset", 64'(enemy_offset), 64'd4);
      chk("lit_step1_anim", 64'(animation_offset), 64'd8);
      tick_n(16);
      chk("lit_step2_offset", 64'(enemy_offset), 64'd8);
      chk("lit_step2_anim", 64'(animation_offset), 64'd0);

      // freeze mid-count holds the counter
      tick_n(5);
      freeze = 1'b1;
      tick_n(20);
      chk("lit_freeze_offset", 64'(enemy_offset), 64'd8);
      freeze = 1'b0;
      tick_n(11);
      chk("lit_unfreeze_offset", 64'(enemy_offset), 64'd12);
      chk("lit_unfreeze_anim", 64'(animation_offset), 64'd8);

      // right edge with lmax = 7
      steps(37);
      chk("lit_edge_offset", 64'(enemy_offset), 64'd160);
      steps(1);
      chk("lit_flip_offset", 64'(enemy_offset), 64'd160);
      steps(1);
      chk("lit_left_offset", 64'(enemy_offset), 64'd156);

      // kill column 7 and rows 0..4 of column 6
      #1 k0 = kills_seen;
      for (int r = 0; r < 6; r++) hit(7, r);
      for (int r = 0; r < 5; r++) hit(6, r);
      hit(7, 0);
      hit(12, 0);
      hit(3, 6);
      @(negedge Clk);
      #1 chk("lit_kill_count", 64'(kills_seen - k0), 64'd11);
      chk("lit_kill_status", 64'(enemy_status), 64'h000020FFFFFFFFF);

      // left to 0, flip, right to 224 (lmax = 6)
      steps(96);
      chk("lit_edge6_offset", 64'(enemy_offset), 64'd224);
      // last col-6 invader dies on the same clock as the step: bound still uses lmax 6
      tick_n(15);
      tick_hit(6, 5);
      chk("lit_coinc_offset", 64'(enemy_offset), 64'd224);
      chk("lit_coinc_status", 64'(enemy_status), 64'h000000FFFFFFFFF);
      #1 chk("lit_coinc_kills", 64'(kills_seen - k0), 64'd12);
      steps(1);
      chk("lit_after_coinc", 64'(enemy_offset), 64'd220);

      // wipe the wave
      for (int c = 0; c < 6; c++)
         for (int r = 0; r < 6; r++) hit(c, r);
      chk("lit_clear_pending", 64'(wave_clear), 64'd0);
      @(negedge Clk);
      chk("lit_wave_clear", 64'(wave_clear), 64'd1);
      hit(0, 0);
      tick_n(119);
      chk("lit_wclr_119", 64'(wave_clear), 64'd1);
      tick_n(1);
      chk("lit_reload_wclr", 64'(wave_clear), 64'd0);
      @(negedge Clk);
      chk("lit_reload_status", 64'(enemy_status), 64'(INIT_STAT));
      chk("lit_reload_offset", 64'(enemy_offset), 64'd0);
      chk("lit_reload_anim", 64'(animation_offset), 64'd0);
      steps(2);
      chk("lit_wave2_offset", 64'(enemy_offset), 64'd8);

      // clear again, reset asynchronously mid-delay
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 6; r++) hit(c, r);
      @(negedge Clk);
      tick_n(50);
      chk("lit_mid_clear", 64'(wave_clear), 64'd1);
      #2 Reset_n = 1'b0;
      #1;
      chk("lit_async_offset", 64'(enemy_offset), 64'd0);
      chk("lit_async_status", 64'(enemy_status), 64'(INIT_STAT));
      chk("lit_async_wclr", 64'(wave_clear), 64'd0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      steps(1);
      chk("lit_post_reset", 64'(enemy_offset), 64'd4);
      repeat (2) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
